// File: rtl/cs_pkg.sv
// Shared constants for the CS result path and its output buffer.
package cs_pkg;

  localparam int CS_Y_W    = 10;
  localparam int CS_WARMUP = 9;

  // Width of a counter that must hold the value n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cs_sync_fifo.sv
// Show-ahead synchronous FIFO: registered head word, explicit level counter.
module cs_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;
  logic          bypass;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty && !reset;
  assign do_push = push && !reset && (!full || do_pop);
  assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  // Incoming word becomes the head directly when nothing older survives this edge.
  assign bypass  = do_push && (empty || (level == LW'(1) && do_pop));

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
      dout <= bypass ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/cs_out_buf.sv
// Output buffer for the CS result stream: discards the warm-up samples, then
// buffers one sample per cycle for a ready/valid consumer with a sticky drop flag.
module cs_out_buf
  import cs_pkg::*;
#(
  parameter int W      = CS_Y_W,
  parameter int DEPTH  = 8,
  parameter int WARMUP = CS_WARMUP
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [W-1:0]                 Y,
  output logic [W-1:0]                 out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int CW = cnt_width(WARMUP);

  logic [CW-1:0] warm_cnt;
  logic          warm_done;
  logic          full;
  logic          empty;
  logic          drop;

  assign warm_done = (warm_cnt == CW'(WARMUP));
  assign out_valid = !empty;
  // When full the buffer is never empty, so a pop is exactly out_ready.
  assign drop      = warm_done && full && !out_ready;

  always_ff @(posedge clk) begin
    if (reset)           warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  cs_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (warm_done),
    .pop   (out_ready),
    .din   (Y),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
